// File: rtl/aes_types_pkg.sv
// Shared AES sizing constants and block/word types.
// The gearbox defaults to these so an AES state or key load is one
// 128-bit block assembled from four 32-bit bus words.
package aes_types_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = AES_BLOCK_W / AES_WORD_W;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;

endpackage

// File: rtl/gearbox_lane_insert.sv
// Combinational lane merge: returns acc with word written into the lane
// selected by idx. With MSB_FIRST=1, idx 0 is the top lane; otherwise
// idx 0 is the bottom lane. All other lanes pass acc through unchanged.
//   acc    : current accumulator (OUT_W)
//   word   : incoming word (IN_W)
//   idx    : word index within the block (CNT_W)
//   merged : acc with the selected lane replaced (OUT_W)
module gearbox_lane_insert
    import aes_types_pkg::*;
#(
    parameter int IN_W      = AES_WORD_W,
    parameter int RATIO     = AES_WORDS_PER_BLOCK,
    parameter bit MSB_FIRST = 1'b1,
    localparam int OUT_W    = IN_W * RATIO,
    localparam int CNT_W    = $clog2(RATIO + 1)
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [IN_W-1:0]  word,
    input  logic [CNT_W-1:0] idx,
    output logic [OUT_W-1:0] merged
);

    // Each physical lane owns exactly one assign; the index-to-lane
    // mapping is resolved at elaboration time.
    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        localparam int POS = MSB_FIRST ? (RATIO - 1 - g) : g;
        assign merged[POS*IN_W +: IN_W] =
            (idx == CNT_W'(g)) ? word : acc[POS*IN_W +: IN_W];
    end

endmodule

// File: rtl/word_to_block_gearbox.sv
// Narrow-to-wide gearbox: packs RATIO words of IN_W bits into one OUT_W
// block with valid/ready on both sides. in_last closes a block early
// (unwritten lanes stay zero). flush clears everything synchronously.
//   clk, reset_n              : clock, async active-low reset
//   flush                     : synchronous clear, dominates all inputs
//   in_data/in_valid/in_last  : word input, in_ready back-pressure
//   out_data/out_valid        : assembled block, out_ready from consumer
//   out_beats                 : words carried by out_data (1..RATIO)
//   out_last                  : block was closed by in_last
//   fill_level                : words currently held in the accumulator
module word_to_block_gearbox
    import aes_types_pkg::*;
#(
    parameter int IN_W      = AES_WORD_W,
    parameter int RATIO     = AES_WORDS_PER_BLOCK,
    parameter bit MSB_FIRST = 1'b1,
    localparam int OUT_W    = IN_W * RATIO,
    localparam int CNT_W    = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_last,
    output logic [CNT_W-1:0] fill_level
);

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] merged;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             xfer;
    logic             complete;

    gearbox_lane_insert #(
        .IN_W      (IN_W),
        .RATIO     (RATIO),
        .MSB_FIRST (MSB_FIRST)
    ) u_insert (
        .acc    (acc),
        .word   (in_data),
        .idx    (cnt),
        .merged (merged)
    );

    // A held block blocks the accumulator too, even for non-completing
    // words, so block order on the output always matches word order.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign xfer       = out_valid && out_ready;
    assign complete   = accept && ((cnt == CNT_W'(RATIO - 1)) || in_last);
    assign fill_level = cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_beats <= '0;
            out_last  <= 1'b0;
        end else if (flush) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_beats <= '0;
            out_last  <= 1'b0;
        end else begin
            // out_data/beats/last deliberately hold after a transfer.
            if (xfer) begin
                out_valid <= 1'b0;
            end
            if (complete) begin
                out_data  <= merged;
                out_valid <= 1'b1;
                out_beats <= cnt + CNT_W'(1);
                out_last  <= in_last;
                acc       <= '0;
                cnt       <= '0;
            end else if (accept) begin
                acc <= merged;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/word_to_block_gearbox.md
Name: word_to_block_gearbox

Overview:
- Parametrised narrow-to-wide width converter: packs RATIO input words of IN_W bits into one OUT_W-bit block.
- Primary use is feeding 32-bit bus words into the 128-bit AES datapath (state/key loading).
- Valid/ready handshake on both sides.
- Selectable lane order.
- Early termination with zero padding via in_last.
- Synchronous flush.

Parameters:
- IN_W, 32, input word width in bits (>=1)
- RATIO, 4, input words per output block (>=2)
- OUT_W, IN_W*RATIO, output block width (derived; not to be overridden)
- MSB_FIRST, 1, 1: first accepted word lands in the top lane; 0: first word lands in the bottom lane
- CNT_W, $clog2(RATIO+1), width of beat counters (derived)

Ports:
- clk  in  1  main clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of accumulator and output register; dominates all other inputs
- in_data  in  IN_W  input word
- in_valid  in  1  input word valid
- in_last  in  1  accepted word is the final one of the current block
- in_ready  out  1  block can accept a word this cycle
- out_data  out  OUT_W  assembled block
- out_valid  out  1  out_data holds a complete or terminated block
- out_ready  in  1  consumer takes the block this cycle
- out_beats  out  CNT_W  number of valid input words in out_data (1..RATIO)
- out_last  out  1  block was closed by in_last
- fill_level  out  CNT_W  words currently in the accumulator (0..RATIO-1)

Behaviour:
- Reset (async assert, sync release):
  - accumulator = 0, beat counter = 0.
  - out_data = 0, out_valid = 0, out_beats = 0, out_last = 0.
  - fill_level = 0; in_ready therefore reads 1.
- Handshake and acceptance:
  - in_ready = !out_valid || out_ready (combinational).
  - An input word is accepted when in_valid && in_ready.
  - An output block is transferred when out_valid && out_ready.
- Lane placement for accepted word at index k = fill_level:
  - MSB_FIRST=1: written to bits [OUT_W-1-k*IN_W -: IN_W].
  - MSB_FIRST=0: written to bits [k*IN_W +: IN_W].
  - Lanes not yet written hold 0.
- Block completion: the accepted word completes the block when k == RATIO-1 or in_last == 1. On the same clock edge:
  - out_data <= accumulator with the new lane merged.
  - out_valid <= 1; out_beats <= k+1; out_last <= in_last.
  - accumulator <= 0; counter <= 0.
- Non-completing accept: lane written, counter increments; out_* unchanged.
- Latency and throughput:
  - out_valid rises the cycle after the completing word is accepted.
  - With out_ready held 1, one word is accepted per cycle with no bubbles; a block is produced every RATIO cycles.
- Transfer with no simultaneous completion: out_valid <= 0. out_data, out_beats and out_last hold their last values (not cleared).
- Simultaneous transfer and completion in the same cycle: the new block is loaded; out_valid stays 1.
- Backpressure: while out_valid && !out_ready, in_ready = 0. The accumulator is frozen, even if the next word would not complete a block.
- in_last on the RATIO-th word: normal full block, out_beats = RATIO, out_last = 1.
- in_last on the first word: out_beats = 1, and only one lane is non-zero.
- flush = 1:
  - Next edge: accumulator = 0, counter = 0, out_valid = 0, out_last = 0, out_beats = 0.
  - Any word or block handshaking that cycle is discarded.
- in_valid while in_ready = 0: ignored. Source must hold data (standard valid/ready).
- Reset asserted mid-block: all partial data lost, immediate return to reset values.
- No arithmetic beyond the counter. The counter never exceeds RATIO-1 in the accumulator state.

Decomposition:
- Shared package aes_types_pkg:
  - AES_BLOCK_W = 128, AES_WORD_W = 32, AES_WORDS_PER_BLOCK = 4.
  - typedefs aes_block_t (logic [127:0]) and aes_word_t (logic [31:0]).
- AES instances use IN_W = AES_WORD_W, RATIO = AES_WORDS_PER_BLOCK.
- One combinational sub-module, gearbox_lane_insert: takes the accumulator, word, index and MSB_FIRST; returns the merged vector.
- Counter, handshake and output register stay in the top.

Test Plan (IN_W=32, RATIO=4 unless noted):
1. Reset release with in_valid = 0 → out_valid = 0, out_data = 0, fill_level = 0, in_ready = 1.
2. MSB_FIRST=1, words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles, out_ready = 1 → next cycle out_data = 0x00112233_44556677_8899AABB_CCDDEEFF, out_beats = 4, out_last = 0.
3. MSB_FIRST=0, same words → out_data = 0xCCDDEEFF_8899AABB_44556677_00112233.
4. MSB_FIRST=1, two words 0xAAAAAAAA then 0xBBBBBBBB with in_last on the second → out_data = 0xAAAAAAAA_BBBBBBBB_00000000_00000000, out_beats = 2, out_last = 1.
5. out_ready = 0 after a block completes, 8 words continuously offered → in_ready = 0 and fill_level stays 0 until out_ready = 1. Then the second block is assembled with no word lost or duplicated, checked against a scoreboard.
6. Mid-block events:
   - After 2 words accepted: flush for 1 cycle → fill_level = 0 and no out_valid. The next 4 words form a clean block with no residue.
   - Same sequence, repeated with reset_n pulsed low asynchronously mid-cycle instead of flush → outputs are at reset values before the next edge.
